sc_et_accum: RTL and testbench
==============================

# sc_et_accum

Stochastic-to-binary back end that sits directly downstream of the bitstream-generation stage. It consumes N parallel stochastic bitstreams, counts ones per channel over a run-time-selectable stream length of 2^L cycles (early termination), scales each count to TW-bit binary and presents the results through a valid/ready handshake. The generator's `done` (counter overflow) is also accepted as a hard stop.

## Interface
- `TW`, 8: full-precision width; full stream length is 2^TW cycles.
- `N`, 1: number of parallel stochastic channels.
- `LW`, $clog2(TW+1): width of the length-select input.

- `clk`  in  1  clock (one clock domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new run; accepted only in IDLE.
- `len_log2`  in  LW  L, the log2 of the stream length; sampled with `start`; values >TW clamp to TW.
- `x`  in  N  stochastic bits, one per channel, sampled every RUN cycle.
- `sng_done`  in  1  generator overflow; forces termination.
- `busy`  out  1  high in RUN.
- `out_valid`  out  1  results valid (HOLD).
- `out_ready`  in  1  consumer accepts results.
- `result`  out  N×TW  scaled per-channel values.
- `raw_cnt`  out  N×(TW+1)  unscaled ones counts.
- `cycles`  out  TW+1  number of samples taken.
- `trunc`  out  1  run ended by `sng_done` before 2^L samples.

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE: on `start`, latch L = min(`len_log2`, TW); clear ones counters and cycle counter; go to RUN.
- RUN: each cycle, per channel `cnt[i] += x[i]`; `ccnt += 1`. Termination is evaluated on the post-increment values:
  - `ccnt == 2^L` → HOLD, `trunc` = 0.
  - else `sng_done` = 1 → HOLD, `trunc` = 1; this cycle's sample is included.
  - If both conditions hold in the same cycle, `trunc` = 0.
- Scaling: `result[i] = cnt[i] << (TW-L)`, truncated to TW bits. If `cnt[i] == 2^L` (all ones), `result[i]` saturates to 2^TW-1. The same scaling applies when `trunc` = 1.
- Counter widths: `cnt` and `ccnt` are TW+1 bits and cannot overflow, because the run caps at 2^TW samples.
- HOLD: `result`, `raw_cnt`, `cycles` and `trunc` are stable while `out_valid` = 1. When `out_valid && out_ready`, go to IDLE.
- `start` is ignored in RUN and HOLD.
- L = 0 gives a one-sample run.

## Timing
- Reset values: state IDLE; `busy`, `out_valid` and `trunc` = 0; `result`, `raw_cnt` and `cycles` = 0.
- `start` accepted at edge t → RUN during cycles t+1 … t+2^L (samples of `x` taken at those edges) → `out_valid` = 1 from cycle t+2^L+1.
- All outputs are registered. `result` is computed on the HOLD-entry edge, not combinationally from `cnt`.
- Handshake transfer completes on the edge where `out_valid && out_ready`. `out_valid` drops the next cycle.
- Minimum start-to-start spacing: 2^L+2 cycles.
- `out_ready` may be held high continuously.
- Asserting `rst_n` low mid-run aborts the run immediately. No partial result is emitted.

## Structure
- Package `sc_et_pkg` holds:
  - the `state_t` enum {IDLE, RUN, HOLD};
  - a `clamp_len` function (min of L and TW);
  - a `scale_sat` function (shift plus saturation).
- One sub-module, `sc_ones_cnt`, is natural: a single-channel TW+1-bit ones counter with clear/enable. It is instantiated N times via a generate loop.
- The FSM, cycle counter and output registers live in the top module.

## Test plan
- TW=8, L=3, `x[0]` = 1 every cycle → `raw_cnt` = 8, `result` = 255 (saturated), `cycles` = 8, `trunc` = 0, `out_valid` at start+9.
- TW=8, L=4, `x[0]` pattern 1010… → `raw_cnt` = 8, `result` = 128.
- TW=8, L=8, `sng_done` pulsed on the 100th RUN cycle with `x` all zero → `cycles` = 100, `trunc` = 1, `result` = 0. A separate run with `sng_done` on cycle 256 → `trunc` = 0.
- `len_log2` = 12 with TW=8 → run lasts 256 cycles. `len_log2` = 0 → 1 sample; with `x` = 1, `result` = 255.
- Hold `out_ready` low for 20 cycles in HOLD while toggling `x` and pulsing `start` → outputs stable, no new run. Then raise `out_ready` → IDLE next cycle, and a fresh `start` is accepted.
- Drop `rst_n` midway through an L=6 run → all outputs 0 and state IDLE asynchronously. A new run after release produces a correct count with no residue from the aborted run.

Source files
------------

// File: rtl/sc_et_pkg.sv
// Shared types and helpers for the stochastic-to-binary accumulator.
// Length clamping and count scaling live here so all units agree.
package sc_et_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Stream length exponent can never exceed full precision
   function automatic int clamp_len(input int l, input int tw);
      return (l > tw) ? tw : l;
   endfunction

   // Scale a 2^l-sample count to tw bits; an all-ones count pins to max
   function automatic int unsigned scale_sat(
      input int unsigned cnt,
      input int          l,
      input int          tw
   );
      int unsigned full;
      int unsigned mask;
      full = 32'd1 << l;
      mask = (32'd1 << tw) - 32'd1;
      if (cnt == full) begin
         return mask;
      end
      return (cnt << (tw - l)) & mask;
   endfunction

endpackage

// File: rtl/sc_ones_cnt.sv
// Single-channel ones counter with synchronous clear and enable.
// Exposes the post-increment value so termination can use it.
module sc_ones_cnt #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic         x,
   output logic [W-1:0] cnt_inc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise add this cycle's bit
   always_comb begin
      cnt_inc = cnt_q + W'(x);
      cnt_d   = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_inc;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sc_et_accum.sv
// Early-terminating stochastic accumulator: counts ones over 2^L
// samples per channel, scales to binary, offers via valid/ready.
module sc_et_accum
   import sc_et_pkg::*;
#(
   parameter int TW = 8,
   parameter int N  = 1,
   parameter int LW = $clog2(TW + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [LW-1:0]         len_log2,
   input  logic [N-1:0]          x,
   input  logic                  sng_done,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N*TW-1:0]       result,
   output logic [N*(TW+1)-1:0]   raw_cnt,
   output logic [TW:0]           cycles,
   output logic                  trunc
);

   localparam int CW = TW + 1;

   state_t          state_q;
   state_t          state_d;
   logic [LW-1:0]   l_q;
   logic [LW-1:0]   l_d;
   logic [CW-1:0]   ccnt_q;
   logic [CW-1:0]   ccnt_d;
   logic [CW-1:0]   ccnt_inc;
   logic [CW-1:0]   len_cnt;
   logic            len_hit;
   logic            trunc_q;
   logic            trunc_d;
   logic [N*TW-1:0] res_q;
   logic [N*TW-1:0] res_d;
   logic [N*CW-1:0] raw_q;
   logic [N*CW-1:0] raw_d;
   logic [CW-1:0]   cyc_q;
   logic [CW-1:0]   cyc_d;
   logic [N*CW-1:0] cnt_inc;
   logic            clr;
   logic            en;

   for (genvar i = 0; i < N; i++) begin : g_ch
      sc_ones_cnt #(
         .W(CW)
      ) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (clr),
         .en     (en),
         .x      (x[i]),
         .cnt_inc(cnt_inc[i*CW +: CW])
      );
   end

   // Termination is judged on the post-increment sample count
   always_comb begin
      ccnt_inc = ccnt_q + CW'(1);
      len_cnt  = CW'(1) << l_q;
      len_hit  = (ccnt_inc == len_cnt);
   end

   // FSM, cycle counter and result capture on HOLD entry
   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      ccnt_d  = ccnt_q;
      trunc_d = trunc_q;
      res_d   = res_q;
      raw_d   = raw_q;
      cyc_d   = cyc_q;
      clr     = 1'b0;
      en      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               l_d     = LW'(clamp_len(int'(len_log2), TW));
               ccnt_d  = '0;
               clr     = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            en     = 1'b1;
            ccnt_d = ccnt_inc;
            if (len_hit || sng_done) begin
               state_d = HOLD;
               raw_d   = cnt_inc;
               cyc_d   = ccnt_inc;
               trunc_d = !len_hit;
               for (int i = 0; i < N; i++) begin
                  res_d[i*TW +: TW] = TW'(scale_sat(
                     32'(cnt_inc[i*CW +: CW]),
                     int'(l_q), TW));
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any run in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         l_q     <= '0;
         ccnt_q  <= '0;
         trunc_q <= 1'b0;
         res_q   <= '0;
         raw_q   <= '0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         ccnt_q  <= ccnt_d;
         trunc_q <= trunc_d;
         res_q   <= res_d;
         raw_q   <= raw_d;
         cyc_q   <= cyc_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign out_valid = (state_q == HOLD);
   assign result    = res_q;
   assign raw_cnt   = raw_q;
   assign cycles    = cyc_q;
   assign trunc     = trunc_q;

endmodule

// File: tb/tb_sc_et_accum.sv
// Directed bench for sc_et_accum with an expected-result queue.
// Each run pushes its modelled outcome and pops it on out_valid.
module tb_sc_et_accum;

   localparam int TW = 8;
   localparam int N  = 1;
   localparam int LW = $clog2(TW + 1);

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic [LW-1:0]       len_log2;
   logic [N-1:0]        x;
   logic                sng_done;
   logic                busy;
   logic                out_valid;
   logic                out_ready;
   logic [N*TW-1:0]     result;
   logic [N*(TW+1)-1:0] raw_cnt;
   logic [TW:0]         cycles;
   logic                trunc;

   typedef struct {
      int raw;
      int res;
      int cyc;
      int tr;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   sc_et_accum #(
      .TW(TW),
      .N (N),
      .LW(LW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .len_log2 (len_log2),
      .x        (x),
      .sng_done (sng_done),
      .busy     (busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .raw_cnt  (raw_cnt),
      .cycles   (cycles),
      .trunc    (trunc)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
   endtask

   // l: requested exponent, mode: 0 zeros 1 ones 2 alternating 3 random
   // done_at: RUN cycle carrying sng_done (0 = never)
   // rdy: out_ready level during the run, hold: stall cycles in HOLD
   task automatic run(input int l, input int mode, input int done_at,
                      input bit rdy, input int hold);
      int   lc;
      int   len;
      int   n;
      int   ones;
      int   lat;
      bit   got;
      bit   stable;
      bit   xv[301];
      exp_t e;
      exp_t g;
      lc   = (l > TW) ? TW : l;
      len  = 1 << lc;
      n    = (done_at > 0 && done_at < len) ? done_at : len;
      ones = 0;
      lat  = -1;
      for (int k = 1; k <= 300; k++) begin
         case (mode)
            0:       xv[k] = 1'b0;
            1:       xv[k] = 1'b1;
            2:       xv[k] = bit'(k % 2);
            default: xv[k] = bit'($urandom_range(0, 1));
         endcase
      end
      for (int k = 1; k <= n; k++) ones += int'(xv[k]);
      e.raw = ones;
      e.res = (ones == len) ? 255 : ((ones << (TW - lc)) & 255);
      e.cyc = n;
      e.tr  = (done_at > 0 && done_at < len) ? 1 : 0;
      e.lat = n;
      sb.push_back(e);
      out_ready = rdy;
      @(negedge clk);
      start    = 1'b1;
      len_log2 = LW'(l);
      got      = 1'b0;
      for (int k = 1; k <= 300 && !got; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 1) chk($sformatf("busy_run_L%0d", l), 32'(busy), 1);
         if (out_valid) begin
            got = 1'b1;
            lat = k - 1;
         end else begin
            x        = xv[k];
            sng_done = (k == done_at);
         end
      end
      x        = '0;
      sng_done = 1'b0;
      chk($sformatf("valid_seen_L%0d", l), 32'(got), 1);
      g = sb.pop_front();
      chk($sformatf("latency_L%0d", l), 32'(lat), 32'(g.lat));
      chk($sformatf("raw_cnt_L%0d", l), 32'(raw_cnt), 32'(g.raw));
      chk($sformatf("result_L%0d", l), 32'(result), 32'(g.res));
      chk($sformatf("cycles_L%0d", l), 32'(cycles), 32'(g.cyc));
      chk($sformatf("trunc_L%0d", l), 32'(trunc), 32'(g.tr));
      if (hold > 0) begin
         stable = 1'b1;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            x     = ~x;
            start = (k % 2 == 0);
            if (!out_valid || busy || result !== 8'(g.res) ||
                raw_cnt !== 9'(g.raw) || cycles !== 9'(g.cyc))
               stable = 1'b0;
         end
         start = 1'b0;
         x     = '0;
         chk("hold_stable", 32'(stable), 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("valid_drop_L%0d", l), 32'(out_valid), 0);
      chk($sformatf("idle_L%0d", l), 32'(busy), 0);
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      len_log2  = '0;
      x         = '0;
      sng_done  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_raw", 32'(raw_cnt), 0);
      chk("rst_cycles", 32'(cycles), 0);
      chk("rst_trunc", 32'(trunc), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run(3, 1, 0, 1'b1, 0);
      run(4, 2, 0, 1'b0, 0);
      run(8, 0, 100, 1'b0, 0);
      run(8, 3, 256, 1'b1, 0);
      run(12, 3, 0, 1'b0, 0);
      run(0, 1, 0, 1'b0, 0);
      run(2, 3, 0, 1'b0, 20);
      run(5, 3, 0, 1'b1, 0);

      @(negedge clk);
      start    = 1'b1;
      len_log2 = LW'(6);
      x        = '1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_result", 32'(result), 0);
      chk("abort_raw", 32'(raw_cnt), 0);
      chk("abort_cycles", 32'(cycles), 0);
      chk("abort_trunc", 32'(trunc), 0);
      @(negedge clk);
      rst_n = 1'b1;
      x     = '0;
      @(negedge clk);
      run(3, 3, 0, 1'b0, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
